// File: rtl/pcm_framer.sv
// PCM TDM framer: 4-deep code FIFO feeding a sync-slot-led serial frame, MSB first.
// Optional macro PCM_FRAMER_EVEN_INV_EN applies A-law even-bit inversion to DATA words.
module pcm_framer #(
  parameter int          SLOTS     = 4,
  parameter int          CLK_DIV   = 4,
  parameter logic [7:0]  SYNC_WORD = 8'h9B,
  parameter logic [7:0]  IDLE_CODE = 8'hD5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       ser_out,
  output logic       bit_en,
  output logic       frame_sync,
  output logic       underrun,
  output logic [2:0] fifo_level
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

`ifdef PCM_FRAMER_EVEN_INV_EN
  localparam logic [7:0] DATA_XOR = 8'h55;
`else
  localparam logic [7:0] DATA_XOR = 8'h00;
`endif

  typedef enum logic [1:0] {SYNC, DATA, FILL} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [2:0]      bit_q;
  logic [SW-1:0]   slot_q, slot_next;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      count_q;
  logic            tick, load, push, pop, under;

  assign tick      = (div_q == DW'(CLK_DIV - 1));
  assign load      = tick && (bit_q == 3'd7);
  assign slot_next = (slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + SW'(1);
  assign push      = code_valid && code_ready;

  // Load decision uses the pre-push occupancy, so a same-cycle push never bypasses into this slot.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    under   = 1'b0;
    if (load) begin
      if (slot_next == '0) begin
        state_d = SYNC;
        shreg_d = SYNC_WORD;
      end else if (count_q != 3'd0) begin
        state_d = DATA;
        shreg_d = mem[rd_ptr] ^ DATA_XOR;
        pop     = 1'b1;
      end else begin
        state_d = FILL;
        shreg_d = IDLE_CODE;
        under   = 1'b1;
      end
    end else if (tick) begin
      shreg_d = {shreg_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      state_q <= SYNC;
      shreg_q <= SYNC_WORD;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      div_q   <= tick ? '0 : div_q + DW'(1);
      if (tick) bit_q <= bit_q + 3'd1;
      if (load) slot_q <= slot_next;
      state_q <= state_d;
      shreg_q <= shreg_d;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

  assign code_ready = (count_q != 3'd4);
  assign fifo_level = count_q;
  assign ser_out    = shreg_q[7];
  assign bit_en     = tick;
  assign frame_sync = (state_q == SYNC) && (bit_q == 3'd0);
  assign underrun   = under;

endmodule

// File: tb/tb_pcm_framer.sv
// Directed bench for pcm_framer (default parameters): per-cycle serial monitor against a frame scoreboard.
module tb_pcm_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic       ser_out;
  logic       bit_en;
  logic       frame_sync;
  logic       underrun;
  logic [2:0] fifo_level;

  pcm_framer #(.SLOTS(4), .CLK_DIV(4), .SYNC_WORD(8'h9B), .IDLE_CODE(8'hD5)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .ser_out(ser_out), .bit_en(bit_en),
    .frame_sync(frame_sync), .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

`ifdef PCM_FRAMER_EVEN_INV_EN
  localparam logic [7:0] INV = 8'h55;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         und_cnt = 0;
  int         accepted = 0;
  int         push_from = 0;
  bit         rdy_last = 1'b0;
  bit         slot_ok = 1'b1;
  logic [7:0] exp_cur = '0;
  logic [7:0] got = '0;
  logic [7:0] sb[$];
  int         uq[$];
  logic [7:0] pq[$];

  function automatic logic [7:0] dw(input logic [7:0] w);
    return w ^ INV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input int n_under);
    sb.push_back(8'h9B);
    sb.push_back(s1);
    sb.push_back(s2);
    sb.push_back(s3);
    uq.push_back(n_under);
  endtask

  // One clk cycle at the negedge: drive the push queue, then check serial output against the scoreboard.
  task automatic step();
    int slot, b, k, nu;
    slot = cyc / 32;
    b    = (cyc / 4) % 8;
    k    = cyc % 4;
    if (code_valid && rdy_last) begin
      void'(pq.pop_front());
      accepted++;
    end
    if (pq.size() > 0 && cyc >= push_from) begin
      code_valid = 1'b1;
      code_in    = pq[0];
    end else begin
      code_valid = 1'b0;
    end
    rdy_last = code_ready;
    if (k == 0 && b == 0) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
        exp_cur = '0;
      end else begin
        exp_cur = sb.pop_front();
      end
      got     = '0;
      slot_ok = 1'b1;
    end
    if (k == 0) got = {got[6:0], ser_out};
    if (ser_out !== exp_cur[7-b]) slot_ok = 1'b0;
    if (bit_en !== (k == 3)) slot_ok = 1'b0;
    if (frame_sync !== (slot == 0 && b == 0)) slot_ok = 1'b0;
    if (underrun === 1'b1) und_cnt++;
    if (k == 3 && b == 7) begin
      chk($sformatf("slot%0d_byte", slot), {24'd0, got}, {24'd0, exp_cur});
      chk($sformatf("slot%0d_timing", slot), {31'd0, slot_ok}, 32'd1);
    end
    if (cyc == 127) begin
      nu = (uq.size() > 0) ? uq.pop_front() : -1;
      chk("underrun_count", und_cnt, nu);
      und_cnt = 0;
    end
    @(negedge clk);
    cyc = (cyc + 1) % 128;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 1000 && cyc != target; n++) step();
    chk("run_to_reached", cyc, target);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n * 128; i++) step();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    code_valid = 1'b0;
    pq.delete();
    sb.delete();
    uq.delete();
    rdy_last   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    cyc        = 0;
    und_cnt    = 0;
    push_from  = 0;
    chk("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_code_ready", {31'd0, code_ready}, 32'd1);
    chk("rst_ser_out",    {31'd0, ser_out},    32'd1);
    chk("rst_frame_sync", {31'd0, frame_sync}, 32'd1);
    chk("rst_bit_en",     {31'd0, bit_en},     32'd0);
    chk("rst_underrun",   {31'd0, underrun},   32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    code_in    = '0;
    code_valid = 1'b0;
    @(negedge clk);
    do_reset();

    // Idle: sync word then fill codes, three underruns per 128-cycle frame.
    expect_frame(8'hD5, 8'hD5, 8'hD5, 3);
    expect_frame(8'hD5, 8'hD5, 8'hD5, 3);
    run_frames(2);

    // Three words queued before the slot-1 load fill the frame in order.
    pq = '{8'hF3, 8'h0A, 8'h81};
    expect_frame(dw(8'hF3), dw(8'h0A), dw(8'h81), 0);
    run_frames(1);

    // code_valid held against a full FIFO: four accepted, rest wait for pops, nothing lost.
    pq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expect_frame(dw(8'h11), dw(8'h22), dw(8'h33), 0);
    expect_frame(dw(8'h44), dw(8'h55), dw(8'h66), 0);
    accepted = 0;
    run_to(4);
    chk("full_level",     {29'd0, fifo_level}, 32'd4);
    chk("full_not_ready", {31'd0, code_ready}, 32'd0);
    run_to(6);
    chk("accepted_in_6",  accepted, 4);
    run_to(31);
    chk("still_full",     {29'd0, fifo_level}, 32'd4);
    chk("still_blocked",  {31'd0, code_ready}, 32'd0);
    run_to(32);
    chk("after_pop_level", {29'd0, fifo_level}, 32'd3);
    chk("after_pop_ready", {31'd0, code_ready}, 32'd1);
    run_to(0);
    run_frames(1);
    chk("all_accepted", accepted, 6);

    // Push landing on the slot-1 load into an empty FIFO goes out in slot 2, not slot 1.
    pq = '{8'h77};
    push_from = 31;
    expect_frame(8'hD5, dw(8'h77), 8'hD5, 2);
    run_frames(1);
    push_from = 0;

    // Reset at slot 2 bit 3 with words still queued.
    pq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    expect_frame(dw(8'hA1), dw(8'hA2), 8'hD5, 0);
    run_to(76);
    chk("pre_reset_level", {29'd0, fifo_level}, 32'd2);
    do_reset();
    expect_frame(8'hD5, 8'hD5, 8'hD5, 3);
    run_frames(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
